// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI frame decoder: header, burst write to command bank, burst read from register map
module spi_cmd_decoder #(
    parameter int          ADDR_W      = 7,
    parameter int          RO_REGS     = 64,
    parameter logic [15:0] CMD_RST_VAL = 16'h0000
) (
    input  logic                                  SYS_CLK,
    input  logic                                  RST_N,
    input  logic                                  FRAME_START,
    input  logic                                  FRAME_END,
    input  logic                                  RX_VALID,
    input  logic [15:0]                           RX_DATA,
    input  logic [RO_REGS*16-1:0]                 STATUS_REG,
    output logic [((1<<ADDR_W)-RO_REGS)*16-1:0]   COMMAND_REG,
    output logic [15:0]                           TX_DATA,
    output logic                                  WR_STROBE,
    output logic [ADDR_W-1:0]                     WR_ADDR,
    output logic [2:0]                            ERR_FLAGS
);

    localparam int NUM_CMD = (1 << ADDR_W) - RO_REGS;
    localparam int RO_W    = $clog2(RO_REGS);
    localparam int CMD_W   = $clog2(NUM_CMD);
    localparam logic [ADDR_W-1:0] CLR_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, HDR, WRITE, READ, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [7:0]               count_q, count_d;
    logic [15:0]              tx_q, tx_d;
    logic [2:0]               err_q, err_d;
    logic [NUM_CMD*16-1:0]    cmd_q, cmd_d;
    logic                     wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic                     err_clear;

    function automatic logic [CMD_W-1:0] cmd_idx(input logic [ADDR_W-1:0] a);
        return CMD_W'(a - ADDR_W'(RO_REGS));
    endfunction

    // Read data is captured when TX_DATA loads, so later map changes do not alter a word in flight.
    function automatic logic [15:0] rd_word(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(RO_REGS))
            return STATUS_REG[{RO_W'(a), 4'b0000} +: 16];
        else
            return cmd_q[{cmd_idx(a), 4'b0000} +: 16];
    endfunction

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            tx_q        <= '0;
            err_q       <= '0;
            cmd_q       <= {NUM_CMD{CMD_RST_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            tx_q        <= tx_d;
            err_q       <= err_d;
            cmd_q       <= cmd_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        tx_d        = tx_q;
        err_d       = err_q;
        cmd_d       = cmd_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_clear   = 1'b0;

        case (state_q)
            HDR: begin
                if (RX_VALID) begin
                    addr_d  = RX_DATA[14:8];
                    count_d = RX_DATA[7:0];
                    if (RX_DATA[7:0] == 8'd0) begin
                        state_d   = DRAIN;
                        err_clear = (RX_DATA[14:8] == CLR_ADDR);
                    end else if (RX_DATA[15]) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                        tx_d    = rd_word(RX_DATA[14:8]);
                    end
                end
            end
            WRITE: begin
                if (RX_VALID) begin
                    if (addr_q >= ADDR_W'(RO_REGS)) begin
                        cmd_d[{cmd_idx(addr_q), 4'b0000} +: 16] = RX_DATA;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1)
                        state_d = DRAIN;
                end
            end
            READ: begin
                if (RX_VALID) begin
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = DRAIN;
                        tx_d    = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        tx_d   = rd_word(addr_q + 1'b1);
                    end
                end
            end
            DRAIN: begin
                if (RX_VALID)
                    err_d[1] = 1'b1;
            end
            default: ;
        endcase

        // Frame boundaries apply after the word of this cycle, so a final word with FRAME_END is not an early end.
        if (FRAME_START || FRAME_END) begin
            if ((state_d == WRITE || state_d == READ) && count_d != 8'd0)
                err_d[2] = 1'b1;
            tx_d    = '0;
            state_d = FRAME_START ? HDR : IDLE;
        end

        if (err_clear)
            err_d = '0;
    end

    assign COMMAND_REG = cmd_q;
    assign TX_DATA     = tx_q;
    assign WR_STROBE   = wr_strobe_q;
    assign WR_ADDR     = wr_addr_q;
    assign ERR_FLAGS   = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - directed self-checking bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

    logic          SYS_CLK = 1'b0;
    logic          RST_N;
    logic          FRAME_START;
    logic          FRAME_END;
    logic          RX_VALID;
    logic [15:0]   RX_DATA;
    logic [1023:0] STATUS_REG;
    logic [1023:0] COMMAND_REG;
    logic [15:0]   TX_DATA;
    logic          WR_STROBE;
    logic [6:0]    WR_ADDR;
    logic [2:0]    ERR_FLAGS;

    int checks = 0;
    int errors = 0;
    logic [6:0] strobe_q[$];

    spi_cmd_decoder dut (
        .SYS_CLK     (SYS_CLK),
        .RST_N       (RST_N),
        .FRAME_START (FRAME_START),
        .FRAME_END   (FRAME_END),
        .RX_VALID    (RX_VALID),
        .RX_DATA     (RX_DATA),
        .STATUS_REG  (STATUS_REG),
        .COMMAND_REG (COMMAND_REG),
        .TX_DATA     (TX_DATA),
        .WR_STROBE   (WR_STROBE),
        .WR_ADDR     (WR_ADDR),
        .ERR_FLAGS   (ERR_FLAGS)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(negedge SYS_CLK)
        if (RST_N && WR_STROBE) strobe_q.push_back(WR_ADDR);

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic send_word(input logic [15:0] w, input logic with_end);
        @(negedge SYS_CLK);
        RX_DATA   = w;
        RX_VALID  = 1'b1;
        FRAME_END = with_end;
        @(negedge SYS_CLK);
        RX_VALID  = 1'b0;
        FRAME_END = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge SYS_CLK);
        FRAME_START = 1'b1;
        @(negedge SYS_CLK);
        FRAME_START = 1'b0;
    endtask

    task automatic frame_end();
        @(negedge SYS_CLK);
        FRAME_END = 1'b1;
        @(negedge SYS_CLK);
        FRAME_END = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        RST_N = 1'b0; FRAME_START = 1'b0; FRAME_END = 1'b0;
        RX_VALID = 1'b0; RX_DATA = '0;
        STATUS_REG = '0;
        STATUS_REG[5*16 +: 16] = 16'hABCD;
        STATUS_REG[6*16 +: 16] = 16'h1234;
        repeat (3) @(negedge SYS_CLK);
        RST_N = 1'b1;
        @(negedge SYS_CLK);
        checks++; if (COMMAND_REG !== '0) begin errors++; $display("FAIL reset_cmd got %h exp 0", COMMAND_REG[63:0]); end
        checks++; if (TX_DATA !== 16'h0) begin errors++; $display("FAIL reset_tx got %h exp 0000", TX_DATA); end
        checks++; if ({WR_STROBE, WR_ADDR, ERR_FLAGS} !== 11'h0) begin errors++; $display("FAIL reset_outs got %b %h %b exp 0 00 000", WR_STROBE, WR_ADDR, ERR_FLAGS); end
        base = strobe_q.size();
        send_word(16'hC001, 1'b0);
        send_word(16'h1234, 1'b0);
        checks++; if (strobe_q.size() - base !== 0) begin errors++; $display("FAIL idle_ignore_strobes got %0d exp 0", strobe_q.size() - base); end
        checks++; if (COMMAND_REG[15:0] !== 16'h0) begin errors++; $display("FAIL idle_ignore_cmd got %h exp 0000", COMMAND_REG[15:0]); end
    endtask

    task automatic test_write_burst();
        int base;
        base = strobe_q.size();
        frame_start();
        send_word(16'hC003, 1'b0);
        send_word(16'h1111, 1'b0);
        checks++; if ({WR_STROBE, WR_ADDR} !== {1'b1, 7'd64} || COMMAND_REG[15:0] !== 16'h1111) begin
            errors++; $display("FAIL wr_latency got %b %0d %h exp 1 64 1111", WR_STROBE, WR_ADDR, COMMAND_REG[15:0]); end
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        frame_end();
        checks++; if (COMMAND_REG[47:0] !== 48'h3333_2222_1111) begin errors++; $display("FAIL wr_data got %h exp 333322221111", COMMAND_REG[47:0]); end
        checks++; if (strobe_q.size() - base !== 3) begin errors++; $display("FAIL wr_strobes got %0d exp 3", strobe_q.size() - base); end
        else begin
            checks++; if ({strobe_q[base], strobe_q[base+1], strobe_q[base+2]} !== {7'd64, 7'd65, 7'd66}) begin
                errors++; $display("FAIL wr_addrs got %0d %0d %0d exp 64 65 66", strobe_q[base], strobe_q[base+1], strobe_q[base+2]); end
        end
        checks++; if (ERR_FLAGS !== 3'b000) begin errors++; $display("FAIL wr_err got %b exp 000", ERR_FLAGS); end
    endtask

    task automatic test_read_burst();
        int base;
        base = strobe_q.size();
        frame_start();
        send_word(16'h0502, 1'b0);
        checks++; if (TX_DATA !== 16'hABCD) begin errors++; $display("FAIL rd_first got %h exp abcd", TX_DATA); end
        send_word(16'h0000, 1'b0);
        checks++; if (TX_DATA !== 16'h1234) begin errors++; $display("FAIL rd_second got %h exp 1234", TX_DATA); end
        send_word(16'h0000, 1'b0);
        checks++; if (TX_DATA !== 16'h0000) begin errors++; $display("FAIL rd_done got %h exp 0000", TX_DATA); end
        frame_end();
        checks++; if (strobe_q.size() - base !== 0 || ERR_FLAGS !== 3'b000) begin
            errors++; $display("FAIL rd_side got strobes %0d err %b exp 0 000", strobe_q.size() - base, ERR_FLAGS); end
    endtask

    task automatic test_ro_wrap();
        int base;
        base = strobe_q.size();
        frame_start();
        send_word(16'hFF02, 1'b0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b0);
        frame_end();
        checks++; if (COMMAND_REG[1023:1008] !== 16'hAAAA) begin errors++; $display("FAIL wrap_reg127 got %h exp aaaa", COMMAND_REG[1023:1008]); end
        checks++; if (strobe_q.size() - base !== 1) begin errors++; $display("FAIL wrap_strobes got %0d exp 1", strobe_q.size() - base); end
        checks++; if (ERR_FLAGS !== 3'b001) begin errors++; $display("FAIL wrap_err got %b exp 001", ERR_FLAGS); end
    endtask

    task automatic test_overrun_early_end();
        int base;
        frame_start();
        send_word(16'hC001, 1'b0);
        send_word(16'h4444, 1'b0);
        send_word(16'h5555, 1'b0);
        checks++; if (ERR_FLAGS !== 3'b011) begin errors++; $display("FAIL overrun_err got %b exp 011", ERR_FLAGS); end
        checks++; if (COMMAND_REG[15:0] !== 16'h4444) begin errors++; $display("FAIL overrun_data got %h exp 4444", COMMAND_REG[15:0]); end
        frame_end();
        base = strobe_q.size();
        frame_start();
        send_word(16'hC004, 1'b0);
        send_word(16'h6666, 1'b0);
        frame_end();
        checks++; if (ERR_FLAGS !== 3'b111) begin errors++; $display("FAIL early_end_err got %b exp 111", ERR_FLAGS); end
        checks++; if (strobe_q.size() - base !== 1 || COMMAND_REG[31:0] !== 32'h2222_6666) begin
            errors++; $display("FAIL early_end_commit got %0d %h exp 1 22226666", strobe_q.size() - base, COMMAND_REG[31:0]); end
    endtask

    task automatic test_clear();
        frame_start();
        send_word(16'h7F00, 1'b0);
        checks++; if (ERR_FLAGS !== 3'b000) begin errors++; $display("FAIL clear_err got %b exp 000", ERR_FLAGS); end
        frame_end();
    endtask

    task automatic test_back_to_back();
        frame_start();
        send_word(16'hC102, 1'b0);
        send_word(16'h7777, 1'b0);
        send_word(16'h8888, 1'b1);
        checks++; if (ERR_FLAGS !== 3'b000) begin errors++; $display("FAIL end_with_last got %b exp 000", ERR_FLAGS); end
        checks++; if (COMMAND_REG[47:16] !== 32'h8888_7777) begin errors++; $display("FAIL end_with_last_data got %h exp 88887777", COMMAND_REG[47:16]); end
        frame_start();
        send_word(16'hC203, 1'b0);
        send_word(16'h9999, 1'b0);
        frame_start();
        checks++; if (ERR_FLAGS !== 3'b100) begin errors++; $display("FAIL restart_err got %b exp 100", ERR_FLAGS); end
        send_word(16'hC301, 1'b0);
        send_word(16'hAAA1, 1'b0);
        frame_end();
        checks++; if (COMMAND_REG[63:32] !== 32'hAAA1_9999) begin errors++; $display("FAIL restart_data got %h exp aaa19999", COMMAND_REG[63:32]); end
    endtask

    task automatic test_reset_mid_burst();
        frame_start();
        send_word(16'hC002, 1'b0);
        send_word(16'h5555, 1'b0);
        checks++; if (WR_STROBE !== 1'b1) begin errors++; $display("FAIL mid_burst_strobe got %b exp 1", WR_STROBE); end
        #1 RST_N = 1'b0;
        #1;
        checks++; if (COMMAND_REG !== '0) begin errors++; $display("FAIL async_reset_cmd got %h exp 0", COMMAND_REG[63:0]); end
        checks++; if ({WR_STROBE, WR_ADDR, ERR_FLAGS, TX_DATA} !== 27'h0) begin
            errors++; $display("FAIL async_reset_outs got %b %h %b %h exp all zero", WR_STROBE, WR_ADDR, ERR_FLAGS, TX_DATA); end
        @(negedge SYS_CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge SYS_CLK);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_ro_wrap();
        test_overrun_early_end();
        test_clear();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
